// File: rtl/ssp_host_driver.sv
// Bus-side initiator for the SSP: each upstream TX byte becomes one TXFIFO write, and
// SSPRXINTR triggers a drain of RX_BURST RXFIFO reads. Optional counters under SSP_HOST_STATS_EN.
module ssp_host_driver #(
    parameter int DATA_WIDTH = 8,
`ifdef SSP_HOST_STATS_EN
    parameter int CNT_WIDTH  = 16,
`endif
    parameter int RX_BURST   = 4
) (
    input  logic                  i_PCLK,
    input  logic                  i_CLEAR,
    input  logic [DATA_WIDTH-1:0] i_TX_DATA,
    input  logic                  i_TX_VALID,
    output logic                  o_TX_READY,
    output logic [DATA_WIDTH-1:0] o_RX_DATA,
    output logic                  o_RX_VALID,
    input  logic                  i_RX_READY,
    output logic                  o_PSEL,
    output logic                  o_PWRITE,
    output logic [DATA_WIDTH-1:0] o_PWDATA,
    input  logic [DATA_WIDTH-1:0] i_PRDATA,
    input  logic                  i_SSPTXINTR,
`ifdef SSP_HOST_STATS_EN
    output logic [CNT_WIDTH-1:0]  o_TX_COUNT,
    output logic [CNT_WIDTH-1:0]  o_RX_COUNT,
`endif
    input  logic                  i_SSPRXINTR
);

    localparam int REM_W = $clog2(RX_BURST + 1);

    typedef enum logic [2:0] {IDLE, WR, WR_GAP, RD, RD_CAP, RD_HOLD} state_e;

    state_e                state_q, state_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  psel_q, psel_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  arbitrate;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        rem_d      = rem_q;
        tx_ready_d = 1'b0;
        pwdata_d   = pwdata_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        arbitrate  = 1'b0;

        case (state_q)
            IDLE: begin
                // A raised o_TX_READY marks the accept cycle: the decision is already made.
                if (tx_ready_q) begin
                    if (i_TX_VALID) begin
                        pwdata_d = i_TX_DATA;
                        state_d  = WR;
                    end
                end else begin
                    arbitrate = 1'b1;
                end
            end
            WR:     state_d = WR_GAP;
            WR_GAP: arbitrate = 1'b1;
            RD: begin
                rem_d   = rem_q - REM_W'(1);
                state_d = RD_CAP;
            end
            RD_CAP: begin
                rx_data_d  = i_PRDATA;
                rx_valid_d = 1'b1;
                state_d    = RD_HOLD;
            end
            RD_HOLD: begin
                if (i_RX_READY) begin
                    rx_valid_d = 1'b0;
                    if (rem_q != '0) begin
                        state_d = RD;
                    end else begin
                        arbitrate = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // RX wins because an RXFIFO overflow loses data while a TX stall only delays it.
        if (arbitrate) begin
            state_d = IDLE;
            if (i_SSPRXINTR) begin
                rem_d   = REM_W'(RX_BURST);
                state_d = RD;
            end else if (i_TX_VALID && !i_SSPTXINTR) begin
                tx_ready_d = 1'b1;
            end
        end

        psel_d   = (state_d == WR) || (state_d == RD);
        pwrite_d = (state_d == WR);
    end

    always_ff @(posedge i_PCLK) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_CLEAR) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            tx_ready_q <= 1'b0;
            psel_q     <= 1'b0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            tx_ready_q <= tx_ready_d;
            psel_q     <= psel_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign o_TX_READY = tx_ready_q;
    assign o_PSEL     = psel_q;
    assign o_PWRITE   = pwrite_q;
    assign o_PWDATA   = pwdata_q;
    assign o_RX_DATA  = rx_data_q;
    assign o_RX_VALID = rx_valid_q;

`ifdef SSP_HOST_STATS_EN
    logic [CNT_WIDTH-1:0] tx_cnt_q, rx_cnt_q;

    always_ff @(posedge i_PCLK) begin
        if (i_CLEAR) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (state_q == WR)     tx_cnt_q <= tx_cnt_q + CNT_WIDTH'(1);
            if (state_q == RD_CAP) rx_cnt_q <= rx_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign o_TX_COUNT = tx_cnt_q;
    assign o_RX_COUNT = rx_cnt_q;
`endif

endmodule
